// File: rtl/sprite_blitter.sv
`timescale 1ns/1ps
// sprite_blitter: copies one sprite (up to 64x64) from a sprite ROM into the
// 320x240 frame buffer during vertical blank, with horizontal mirroring,
// chroma-key transparency and clipping at the buffer edges.
//
// Ports:
//   clk, reset_n          clock, synchronous active-low reset
//   start                 blit request, sampled only when idle
//   src_base              ROM address of sprite pixel (0,0), row-major
//   spr_w, spr_h          sprite size, 0..64
//   dst_x, dst_y          signed 10-bit position of the sprite's top-left corner
//   flip_h                mirror the sprite horizontally
//   vblank                vertical blanking interval
//   src_en/src_addr       ROM read request; src_data arrives one cycle later
//   fb_we/fb_addr/fb_data frame buffer write, held until fb_ready
//   busy, done            blit in progress, one-cycle completion pulse
module sprite_blitter #(
   parameter int unsigned            VBUF_W     = 320,
   parameter int unsigned            VBUF_H     = 240,
   parameter int unsigned            ADDR_WIDTH = 17,
   parameter int unsigned            DATA_WIDTH = 12,
   parameter logic [DATA_WIDTH-1:0]  KEY_COLOR  = DATA_WIDTH'(12'h0f0)
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  start,
   input  logic [ADDR_WIDTH-1:0] src_base,
   input  logic [6:0]            spr_w,
   input  logic [6:0]            spr_h,
   input  logic [9:0]            dst_x,
   input  logic [9:0]            dst_y,
   input  logic                  flip_h,
   input  logic                  vblank,
   output logic                  src_en,
   output logic [ADDR_WIDTH-1:0] src_addr,
   input  logic [DATA_WIDTH-1:0] src_data,
   output logic                  fb_we,
   output logic [ADDR_WIDTH-1:0] fb_addr,
   output logic [DATA_WIDTH-1:0] fb_data,
   input  logic                  fb_ready,
   output logic                  busy,
   output logic                  done
);

   localparam int unsigned CNT_W  = 7;
   localparam int unsigned POS_W  = 10;
   localparam int unsigned SPOS_W = 11;

   localparam logic [2:0] IDLE    = 3'd0;
   localparam logic [2:0] WAIT_VB = 3'd1;
   localparam logic [2:0] FETCH   = 3'd2;
   localparam logic [2:0] LOAD    = 3'd3;
   localparam logic [2:0] WRITE   = 3'd4;
   localparam logic [2:0] DONE    = 3'd5;

   logic [2:0]            state, state_nxt;
   logic [CNT_W-1:0]      cx, cx_nxt, cy, cy_nxt;
   logic [ADDR_WIDTH-1:0] base_r, base_nxt;
   logic [CNT_W-1:0]      w_r, w_nxt, h_r, h_nxt;
   logic [POS_W-1:0]      dx_r, dx_nxt, dy_r, dy_nxt;
   logic                  flip_r, flip_nxt;

   logic                  src_en_nxt, fb_we_nxt, busy_nxt, done_nxt;
   logic [ADDR_WIDTH-1:0] src_addr_nxt, fb_addr_nxt;
   logic [DATA_WIDTH-1:0] fb_data_nxt;

   logic                  advance, last_pix, skip;
   logic [CNT_W-1:0]      col;
   logic [SPOS_W-1:0]     px, py;
   logic [ADDR_WIDTH-1:0] pix_addr;

   // Screen position of the current pixel: sign-extended origin plus counter.
   assign px = {dx_r[POS_W-1], dx_r} + {4'b0000, cx};
   assign py = {dy_r[POS_W-1], dy_r} + {4'b0000, cy};

   // Negative positions show up as a set sign bit; the upper bound is unsigned.
   assign skip = (src_data == KEY_COLOR)
               || px[SPOS_W-1] || (px[POS_W-1:0] >= POS_W'(VBUF_W))
               || py[SPOS_W-1] || (py[POS_W-1:0] >= POS_W'(VBUF_H));

   assign pix_addr = ADDR_WIDTH'(py[POS_W-1:0]) * ADDR_WIDTH'(VBUF_W)
                   + ADDR_WIDTH'(px[POS_W-1:0]);

   assign last_pix = (cx == w_r - 7'd1) && (cy == h_r - 7'd1);

   // State and registered outputs.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state    <= IDLE;
         cx       <= '0;
         cy       <= '0;
         base_r   <= '0;
         w_r      <= '0;
         h_r      <= '0;
         dx_r     <= '0;
         dy_r     <= '0;
         flip_r   <= 1'b0;
         src_en   <= 1'b0;
         src_addr <= '0;
         fb_we    <= 1'b0;
         fb_addr  <= '0;
         fb_data  <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
      end else begin
         state    <= state_nxt;
         cx       <= cx_nxt;
         cy       <= cy_nxt;
         base_r   <= base_nxt;
         w_r      <= w_nxt;
         h_r      <= h_nxt;
         dx_r     <= dx_nxt;
         dy_r     <= dy_nxt;
         flip_r   <= flip_nxt;
         src_en   <= src_en_nxt;
         src_addr <= src_addr_nxt;
         fb_we    <= fb_we_nxt;
         fb_addr  <= fb_addr_nxt;
         fb_data  <= fb_data_nxt;
         busy     <= busy_nxt;
         done     <= done_nxt;
      end
   end

   // Next state, counters and next values of the registered outputs.
   always_comb begin
      state_nxt    = state;
      cx_nxt       = cx;
      cy_nxt       = cy;
      base_nxt     = base_r;
      w_nxt        = w_r;
      h_nxt        = h_r;
      dx_nxt       = dx_r;
      dy_nxt       = dy_r;
      flip_nxt     = flip_r;
      src_addr_nxt = src_addr;
      fb_addr_nxt  = fb_addr;
      fb_data_nxt  = fb_data;
      advance      = 1'b0;
      col          = '0;

      case (state)
         IDLE: begin
            if (start) begin
               base_nxt  = src_base;
               w_nxt     = spr_w;
               h_nxt     = spr_h;
               dx_nxt    = dst_x;
               dy_nxt    = dst_y;
               flip_nxt  = flip_h;
               cx_nxt    = '0;
               cy_nxt    = '0;
               state_nxt = ((spr_w == '0) || (spr_h == '0)) ? DONE : WAIT_VB;
            end
         end
         WAIT_VB: if (vblank) state_nxt = FETCH;
         FETCH:   state_nxt = LOAD;
         LOAD: begin
            if (skip) begin
               advance = 1'b1;
            end else begin
               fb_addr_nxt = pix_addr;
               fb_data_nxt = src_data;
               state_nxt   = WRITE;
            end
         end
         WRITE: if (fb_ready) advance = 1'b1;
         DONE:  state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase

      // Row-major scan: wrap cx at the sprite width and step to the next row.
      if (advance) begin
         if (last_pix) begin
            state_nxt = DONE;
         end else begin
            state_nxt = FETCH;
            if (cx == w_r - 7'd1) begin
               cx_nxt = '0;
               cy_nxt = cy + 7'd1;
            end else begin
               cx_nxt = cx + 7'd1;
            end
         end
      end

      // ROM address for the pixel about to be fetched, mirrored if requested.
      if (state_nxt == FETCH) begin
         col          = flip_r ? (w_r - 7'd1 - cx_nxt) : cx_nxt;
         src_addr_nxt = base_r + ADDR_WIDTH'(cy_nxt) * ADDR_WIDTH'(w_r)
                      + ADDR_WIDTH'(col);
      end

      src_en_nxt = (state_nxt == FETCH);
      fb_we_nxt  = (state_nxt == WRITE);
      done_nxt   = (state_nxt == DONE);
      busy_nxt   = (state_nxt == WAIT_VB) || (state_nxt == FETCH)
                || (state_nxt == LOAD)    || (state_nxt == WRITE);
   end

endmodule

// File: tb/tb_sprite_blitter.sv
`timescale 1ns/1ps
// Bench for sprite_blitter: ROM and frame buffer models, a scan-order
// reference of the expected writes, table vectors, directed corner cases
// and randomized blits.
module tb_sprite_blitter;

   localparam int AW  = 17;
   localparam int DW  = 12;
   localparam int KEY = 'h0f0;

   logic          clk = 1'b0;
   logic          reset_n, start, flip_h, vblank, fb_ready;
   logic [AW-1:0] src_base, src_addr, fb_addr;
   logic [6:0]    spr_w, spr_h;
   logic [9:0]    dst_x, dst_y;
   logic          src_en, fb_we, busy, done;
   logic [DW-1:0] src_data, fb_data;

   always #5 clk = ~clk;

   sprite_blitter dut (
      .clk(clk), .reset_n(reset_n), .start(start), .src_base(src_base),
      .spr_w(spr_w), .spr_h(spr_h), .dst_x(dst_x), .dst_y(dst_y),
      .flip_h(flip_h), .vblank(vblank), .src_en(src_en), .src_addr(src_addr),
      .src_data(src_data), .fb_we(fb_we), .fb_addr(fb_addr), .fb_data(fb_data),
      .fb_ready(fb_ready), .busy(busy), .done(done)
   );

   logic [DW-1:0] rom [0:(1<<AW)-1];
   always @(posedge clk) if (src_en) src_data <= rom[src_addr];

   typedef struct { int addr; int data; } wr_t;
   wr_t got_q[$];
   wr_t exp_q[$];

   always @(posedge clk)
      if (reset_n && fb_we && fb_ready) got_q.push_back('{int'(fb_addr), int'(fb_data)});

   int total = 0;
   int bad   = 0;
   int cyc;
   int vb_cnt = 0;
   bit rand_ready = 0;

   task automatic chk(input string nm, input longint act, input longint want);
      total++;
      if (act != want) begin
         bad++;
         $display("FAIL %s: got %0d want %0d", nm, act, want);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      if (vb_cnt > 0) vb_cnt--;
      vblank = (vb_cnt == 0);
      if (rand_ready) fb_ready = ($urandom_range(0, 3) != 0);
   endtask

   // Reference: walk the sprite in scan order and keep visible opaque pixels.
   task automatic build_exp(input int base, input int w, input int h,
                            input int dx, input int dy, input bit flip);
      exp_q.delete();
      for (int y = 0; y < h; y++)
         for (int x = 0; x < w; x++) begin
            int c, a, pix, px, py;
            c   = flip ? (w - 1 - x) : x;
            a   = (base + y * w + c) % (1 << AW);
            pix = int'(rom[a]);
            px  = dx + x;
            py  = dy + y;
            if (pix != KEY && px >= 0 && px < 320 && py >= 0 && py < 240)
               exp_q.push_back('{py * 320 + px, pix});
         end
   endtask

   task automatic do_start(input int base, input int w, input int h,
                           input int dx, input int dy, input bit flip);
      src_base = AW'(base);
      spr_w    = 7'(w);
      spr_h    = 7'(h);
      dst_x    = 10'(dx);
      dst_y    = 10'(dy);
      flip_h   = flip;
      start    = 1'b1;
      build_exp(base, w, h, dx, dy, flip);
      got_q.delete();
      tick();
      start = 1'b0;
      cyc   = 1;
   endtask

   task automatic wait_done(input string nm, input int budget);
      while (!done && cyc < budget) begin
         tick();
         cyc++;
      end
      if (!done) begin
         total++;
         bad++;
         $display("FAIL %s timeout: got no done after %0d cycles want done", nm, cyc);
      end
   endtask

   task automatic check_writes(input string nm);
      int mis;
      chk({nm, " write count"}, got_q.size(), exp_q.size());
      mis = -1;
      for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
         if (mis < 0 && (got_q[i].addr != exp_q[i].addr || got_q[i].data != exp_q[i].data))
            mis = i;
      total++;
      if (mis >= 0) begin
         bad++;
         $display("FAIL %s write %0d: got addr=%0d data=%h want addr=%0d data=%h", nm, mis,
                  got_q[mis].addr, got_q[mis].data, exp_q[mis].addr, exp_q[mis].data);
      end
   endtask

   task automatic finish_done(input string nm);
      tick();
      chk({nm, " done one cycle"}, done, 0);
      chk({nm, " idle busy"}, busy, 0);
   endtask

   typedef struct {
      int base; int w; int h; int dx; int dy; bit flip;
      int exp_n; int exp_cyc;
   } vec_t;

   initial begin
      vec_t vecs[7];
      logic [DW-1:0] v;
      bit   stable;
      logic [AW-1:0] ha;
      logic [DW-1:0] hd;

      for (int i = 0; i < (1 << AW); i++) begin
         v = DW'(i * 37 + i / 13);
         if (i >= 50000 && i < 60000 && i % 5 == 0) v = DW'(KEY);
         else if (v == DW'(KEY)) v = DW'('h0f1);
         rom[i] = v;
      end
      rom[100] = DW'('habc);
      rom[201] = DW'(KEY);

      // cycles = 2 + 3 per written pixel + 2 per skipped pixel; empty = 1
      vecs[0] = '{100, 1, 1,   0,   0, 0,  1,   5};
      vecs[1] = '{200, 4, 2,  10,   5, 0,  7,  25};
      vecs[2] = '{200, 4, 2,  10,   5, 1,  7,  25};
      vecs[3] = '{300, 4, 4,  -2, 238, 0,  4,  38};
      vecs[4] = '{300, 0, 5,   0,   0, 0,  0,   1};
      vecs[5] = '{1000, 64, 1, 300,  0, 0, 20, 150};
      vecs[6] = '{300, 3, 0,   0,   0, 0,  0,   1};

      reset_n = 1'b0; start = 1'b0; src_base = '0; spr_w = '0; spr_h = '0;
      dst_x = '0; dst_y = '0; flip_h = 1'b0; vblank = 1'b1; fb_ready = 1'b1;
      tick(); tick();
      chk("reset busy", busy, 0);
      chk("reset done", done, 0);
      chk("reset src_en", src_en, 0);
      chk("reset fb_we", fb_we, 0);
      chk("reset src_addr", src_addr, 0);
      chk("reset fb_addr", fb_addr, 0);
      chk("reset fb_data", fb_data, 0);
      reset_n = 1'b1;
      tick();

      // Cycle-exact 1x1 sprite.
      do_start(100, 1, 1, 0, 0, 0);
      chk("1x1 c1 busy", busy, 1);
      chk("1x1 c1 src_en", src_en, 0);
      tick();
      chk("1x1 c2 src_en", src_en, 1);
      chk("1x1 c2 src_addr", src_addr, 100);
      tick();
      chk("1x1 c3 fb_we", fb_we, 0);
      tick();
      chk("1x1 c4 fb_we", fb_we, 1);
      chk("1x1 c4 fb_addr", fb_addr, 0);
      chk("1x1 c4 fb_data", fb_data, 'habc);
      tick();
      chk("1x1 c5 done", done, 1);
      chk("1x1 c5 busy", busy, 0);
      chk("1x1 c5 fb_we", fb_we, 0);
      finish_done("1x1");
      check_writes("1x1");

      // Table vectors at vblank=1, fb_ready=1.
      for (int i = 0; i < 7; i++) begin
         string nm;
         nm = $sformatf("vec%0d", i);
         do_start(vecs[i].base, vecs[i].w, vecs[i].h, vecs[i].dx, vecs[i].dy, vecs[i].flip);
         wait_done(nm, 2000);
         chk({nm, " cycles"}, cyc, vecs[i].exp_cyc);
         chk({nm, " table count"}, got_q.size(), vecs[i].exp_n);
         check_writes(nm);
         finish_done(nm);
      end

      // vblank held low: nothing fetched or written until it rises.
      vb_cnt = 100000;
      tick();
      do_start(200, 4, 2, 10, 5, 0);
      stable = 1;
      for (int i = 0; i < 50; i++) begin
         if (src_en || fb_we || !busy) stable = 0;
         tick();
      end
      chk("vblank wait idle", stable, 1);
      vb_cnt = 0;
      vblank = 1'b1;
      tick();
      chk("vblank first fetch", src_en, 1);
      chk("vblank fetch addr", src_addr, 200);
      cyc = 0;
      wait_done("vblank", 200);
      check_writes("vblank");
      finish_done("vblank");

      // fb_ready low holds the write.
      fb_ready = 1'b0;
      do_start(400, 2, 1, 50, 50, 0);
      while (!fb_we && cyc < 20) begin tick(); cyc++; end
      chk("stall fb_we", fb_we, 1);
      chk("stall fb_addr", fb_addr, 16050);
      ha = fb_addr;
      hd = fb_data;
      stable = 1;
      for (int i = 0; i < 5; i++) begin
         tick();
         if (!fb_we || fb_addr != ha || fb_data != hd || src_en) stable = 0;
      end
      chk("stall held stable", stable, 1);
      fb_ready = 1'b1;
      wait_done("stall", 200);
      check_writes("stall");
      finish_done("stall");

      // start while busy and in DONE is ignored; inputs change mid-blit.
      do_start(200, 4, 2, 10, 5, 0);
      src_base = '0; spr_w = 7'd1; spr_h = 7'd1; dst_x = '0; dst_y = '0;
      start = 1'b1;
      wait_done("ignore", 200);
      chk("ignore cycles", cyc, 25);
      tick();
      start = 1'b0;
      chk("ignore after done busy", busy, 0);
      tick();
      chk("ignore no restart", busy, 0);
      check_writes("ignore");

      // Reset mid-blit, then a normal blit.
      do_start(500, 8, 8, 0, 0, 0);
      repeat (20) tick();
      reset_n = 1'b0;
      tick();
      chk("midrst busy", busy, 0);
      chk("midrst done", done, 0);
      chk("midrst src_en", src_en, 0);
      chk("midrst fb_we", fb_we, 0);
      chk("midrst src_addr", src_addr, 0);
      chk("midrst fb_addr", fb_addr, 0);
      chk("midrst fb_data", fb_data, 0);
      tick();
      reset_n = 1'b1;
      tick();
      chk("midrst idle", busy, 0);
      do_start(600, 3, 3, 100, 100, 1);
      wait_done("postrst", 200);
      chk("postrst cycles", cyc, 29);
      check_writes("postrst");
      finish_done("postrst");

      // Randomized blits with random vblank delay and fb_ready.
      rand_ready = 1;
      for (int n = 0; n < 25; n++) begin
         int base, w, h, dx, dy;
         bit flip;
         string nm;
         nm   = $sformatf("rand%0d", n);
         w    = int'($urandom_range(0, 20));
         h    = int'($urandom_range(0, 20));
         dx   = int'($urandom_range(0, 360)) - 25;
         dy   = int'($urandom_range(0, 280)) - 25;
         flip = 1'($urandom_range(0, 1));
         base = ($urandom_range(0, 1) == 1) ? int'($urandom_range(49000, 59000))
                                            : int'($urandom_range(0, (1 << AW) - 1));
         vb_cnt = int'($urandom_range(0, 10));
         do_start(base, w, h, dx, dy, flip);
         wait_done(nm, 5000);
         check_writes(nm);
         finish_done(nm);
      end
      rand_ready = 0;
      fb_ready   = 1'b1;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
